// File: rtl/cordic_vec.sv
// rtl/cordic_vec.sv - iterative vectoring-mode CORDIC: atan2 (degrees x 2^16) and magnitude of a Q16.16 vector
module cordic_vec #(
  parameter logic [31:0] K = 32'h09B74
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] angle,
  output logic [31:0] mag
);
  localparam int ITER = 16;
  localparam logic signed [31:0] DEG180 = 32'sd11796480;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_SCALE} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]         i_q, i_d;
  logic               zero_q, zero_d;
  logic [31:0]        angle_q, angle_d, mag_q, mag_d;
  logic               done_q, done_d;
  logic signed [31:0] atan_i, x_sh, y_sh;
  logic signed [48:0] prod;

  always_comb begin
    case (i_q)
      4'd0:    atan_i = 32'sd2949120;
      4'd1:    atan_i = 32'sd1740992;
      4'd2:    atan_i = 32'sd919872;
      4'd3:    atan_i = 32'sd466944;
      4'd4:    atan_i = 32'sd234368;
      4'd5:    atan_i = 32'sd117312;
      4'd6:    atan_i = 32'sd58688;
      4'd7:    atan_i = 32'sd29312;
      4'd8:    atan_i = 32'sd14656;
      4'd9:    atan_i = 32'sd7360;
      4'd10:   atan_i = 32'sd3648;
      4'd11:   atan_i = 32'sd1856;
      4'd12:   atan_i = 32'sd896;
      4'd13:   atan_i = 32'sd448;
      4'd14:   atan_i = 32'sd256;
      default: atan_i = 32'sd128;
    endcase
  end

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  assign prod = $signed({{17{x_q[31]}}, x_q}) * $signed({17'b0, K});

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = '0;
          zero_d  = (x_in == 32'd0) && (y_in == 32'd0);
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        // Left half-plane is folded by 180 degrees so the iterations only see x >= 0.
        if (x_q[31]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = y_q[31] ? -DEG180 : DEG180;
        end
        i_d     = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!y_q[31]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        i_d = i_q + 4'd1;
        if (i_q == 4'(ITER - 1)) state_d = S_SCALE;
      end
      default: begin
        // A zero vector has no direction; its iterated angle is meaningless.
        angle_d = zero_q ? 32'd0 : z_q;
        mag_d   = zero_q ? 32'd0 : 32'(prod >>> 16);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign angle = angle_q;
  assign mag   = mag_q;
endmodule

// File: tb/tb_cordic_vec.sv
// tb/tb_cordic_vec.sv - scoreboard bench for cordic_vec against an ideal atan2/hypot model
module tb_cordic_vec;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x_in, y_in;
  logic        ready, done;
  logic [31:0] angle, mag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    real ang;
    real mg;
    real tol_a;
    real tol_m;
    int  done_at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cordic_vec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .ready(ready), .done(done), .angle(angle), .mag(mag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int xv, input int yv, input int acc);
    exp_t e;
    if (xv == 0 && yv == 0) begin
      e.ang = 0.0; e.mg = 0.0; e.tol_a = 0.0; e.tol_m = 0.0;
    end else begin
      e.ang   = $atan2(real'(yv), real'(xv)) * 180.0 / 3.141592653589793 * 65536.0;
      e.mg    = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      e.tol_a = 640.0;
      e.tol_m = 64.0;
    end
    e.done_at = acc + 18;
    sb.push_back(e);
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done at edge %0d", cyc);
      end else begin
        real a, d, m;
        mon_e = sb.pop_front();
        checks++;
        if (cyc !== mon_e.done_at) begin
          errors++;
          $display("FAIL latency done at edge %0d required %0d", cyc, mon_e.done_at);
        end
        a = real'($signed(angle));
        d = a - mon_e.ang;
        if (d > 11796480.0) d = d - 23592960.0;
        else if (d < -11796480.0) d = d + 23592960.0;
        if (d < 0.0) d = -d;
        checks++;
        if (d > mon_e.tol_a) begin
          errors++;
          $display("FAIL angle got %0d required %f +/- %f", $signed(angle), mon_e.ang, mon_e.tol_a);
        end
        m = real'(mag);
        d = m - mon_e.mg;
        if (d < 0.0) d = -d;
        checks++;
        if (d > mon_e.tol_m) begin
          errors++;
          $display("FAIL mag got %0d required %f +/- %f", mag, mon_e.mg, mon_e.tol_m);
        end
      end
    end
  end

  task automatic issue(input int xv, input int yv, input bit track, output int acc);
    @(negedge clk);
    start = 1'b1; x_in = xv; y_in = yv;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    if (track) push_exp(xv, yv, acc);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
    checks++; if (angle !== 32'd0) begin errors++; $display("FAIL reset_angle got %0d required 0", angle); end
    checks++; if (mag !== 32'd0) begin errors++; $display("FAIL reset_mag got %0d required 0", mag); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b required 1", ready); end
  endtask

  task automatic run_vector(input int xv, input int yv);
    int acc, bad;
    issue(xv, yv, 1'b1, acc);
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ready_busy high in %0d cycles required 0", bad); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_edge18 got %b required 1", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_with_done got %b required 1", ready); end
    if (xv < 0 && yv == 0) begin
      checks++;
      if (!($signed(angle) > 0)) begin errors++; $display("FAIL angle_plus180 got %0d required positive", $signed(angle)); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b required 0", done); end
  endtask

  task automatic test_vectors();
    run_vector(65536, 65536);
    run_vector(-65536, 0);
    run_vector(0, -65536);
    run_vector(-65536, -65536);
    run_vector(0, 0);
    run_vector(3 * 65536, -4 * 65536);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int xv, yv;
      xv = $urandom_range(262144, 16384);
      yv = $urandom_range(262144, 16384);
      if ($urandom_range(1, 0) == 1) xv = -xv;
      if ($urandom_range(1, 0) == 1) yv = -yv;
      run_vector(xv, yv);
    end
  endtask

  task automatic test_back_to_back();
    int acc, pulses, bad;
    @(negedge clk);
    start = 1'b1; x_in = 100000; y_in = -50000;
    @(posedge clk);
    #1;
    acc = cyc;
    for (int r = 0; r < 4; r++) push_exp(100000, -50000, acc + 19 * r);
    pulses = 0; bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (ready !== done) bad++;
      if (k == 59) start = 1'b0;
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d required 3", pulses); end
    pulses = 0;
    for (int k = 60; k <= 75; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (ready !== done) bad++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_fourth got %0d required 1", pulses); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_ignore_start();
    int acc, dones;
    issue(131072, 65536, 1'b1, acc);
    repeat (4) @(negedge clk);
    @(negedge clk);
    start = 1'b1; x_in = -200000; y_in = 30000;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int k = 5; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_start dones got %0d required 1", dones); end
  endtask

  task automatic test_reset_mid();
    int acc, dones;
    issue(70000, 90000, 1'b0, acc);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (angle !== 32'd0) begin errors++; $display("FAIL midrst_angle got %0d required 0", angle); end
    checks++; if (mag !== 32'd0) begin errors++; $display("FAIL midrst_mag got %0d required 0", mag); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b required 0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b required 1", ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d required 0", dones); end
    run_vector(-40000, 80000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_vec.md
CORDIC_VEC -- requirements
Module: cordic_vec

Interface
REQ-001 Parameter ITER, default 16: number of CORDIC micro-rotations; fixed at 16, not overridable.
REQ-002 Parameter K, default 32'h09B74: gain compensation 0.607253 x 2^16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 x_in  input  32  signed Q16.16 x coordinate; captured on the accepting edge.
REQ-007 y_in  input  32  signed Q16.16 y coordinate; captured on the accepting edge.
REQ-008 ready  output  1  high only in IDLE state.
REQ-009 done  output  1  registered one-cycle pulse; angle/mag valid in that cycle.
REQ-010 angle  output  32  signed, degrees x 2^16, range (-180,+180].
REQ-011 mag  output  32  unsigned, Q16.16 magnitude sqrt(x^2+y^2).

Function
REQ-012 The block SHALL implement an iterative vectoring-mode CORDIC (atan2 plus magnitude), one micro-rotation per clock, as the inverse of the codebase's rotation-mode sin/cos engine.
REQ-013 FSM states SHALL be IDLE, PRE, ITER, SCALE; IDLE->PRE on start&ready; PRE->ITER; ITER->SCALE after 16 iterations; SCALE->IDLE.
REQ-014 Edge 0 (start sampled in IDLE) SHALL register x_in, y_in into working regs x, y, set z=0, and move to PRE.
REQ-015 PRE (edge 1) SHALL apply the quadrant fold: if x<0 then x=-x, y=-y, z=+180x2^16 when original y>=0, else z=-180x2^16; if x>=0, unchanged; iteration counter i=0.
REQ-016 ITER edges 2..17, step i=0..15: if y[31]==0 then x+=y>>>i, y-=x>>>i, z+=atan_i; else x-=y>>>i, y+=x>>>i, z-=atan_i; all updates use pre-edge values; shifts arithmetic.
REQ-017 atan_i table (degrees x 2^16) SHALL be 2949120, 1740992, 919872, 466944, 234368, 117312, 58688, 29312, 14656, 7360, 3648, 1856, 896, 448, 256, 128.
REQ-018 SCALE (edge 18) SHALL register angle=z, mag=(x*K)>>>16 using a full 49-bit signed product truncated to 32 bits, set done=1, and return to IDLE.
REQ-019 Latency SHALL be exactly 18 rising edges from the accepting edge to the edge that sets done; throughput one result per 19 cycles.
REQ-020 done SHALL be high for exactly one cycle; angle and mag SHALL hold until the next done.
REQ-021 ready SHALL be low from edge 0 through edge 17 and high again in the cycle done is high; start sampled then SHALL be accepted (back-to-back).
REQ-022 start while ready=0 SHALL be ignored with no effect on the operation in flight.
REQ-023 Input range SHALL be |x_in|,|y_in| < 2^29; outside it results are undefined but FSM SHALL still return to IDLE with one done pulse.
REQ-024 x_in=0 and y_in=0 SHALL produce angle=0, mag=0 (forced in SCALE, overriding the iteration result).
REQ-025 x_in<0, y_in=0 SHALL produce angle=+180x2^16 within tolerance, never -180.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, i=0, x=y=z=0, angle=0, mag=0, done=0, hence ready=1.
REQ-027 Reset mid-operation SHALL abort it: no done pulse for the aborted request; first edge after release with start=1 begins a new operation.

Verification
REQ-028 x_in=65536, y_in=65536 -> done on edge 18; angle=2949120+/-640, mag=92682+/-64.
REQ-029 x_in=-65536, y_in=0 -> angle=11796480+/-640 (positive), mag=65536+/-64; x_in=0, y_in=-65536 -> angle=-5898240+/-640, mag=65536+/-64.
REQ-030 x_in=-65536, y_in=-65536 -> angle=-8847360+/-640, mag=92682+/-64; x_in=y_in=0 -> angle=0, mag=0 exactly.
REQ-031 start held high for 60 cycles with fixed inputs -> done pulses on edges 18, 37, 56; ready low in between; identical outputs each time.
REQ-032 pulse start, then pulse start again at edge 5 with different inputs -> single done at edge 18 carrying the first request's result.
REQ-033 assert rst_n=0 at edge 10 of an operation -> angle=mag=0, done=0, ready=1 immediately; no done pulse until a new start is accepted.
